// File: rtl/reg_mem_pkg.sv
// Shared types, default parameters and the parity helper for reg_mem_mp.
package reg_mem_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH = 4;
   localparam int DEF_ADDR_BITS  = 3;
   localparam int DEF_RD_PORTS   = 2;

   // Even parity: the returned bit makes the total count of ones even.
   // Callers zero-extend narrower words; the extension does not change the result.
   function automatic logic parity_even(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/reg_mem_mp_if.sv
// Bus bundle for reg_mem_mp: write port, packed read ports, clear request and status.
interface reg_mem_mp_if #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_BITS  = 3,
   parameter int RD_PORTS   = 2
);
   logic                           wen;
   logic [ADDR_BITS-1:0]           waddr;
   logic [DATA_WIDTH-1:0]          data_in;
   logic [RD_PORTS-1:0]            ren;
   logic [RD_PORTS*ADDR_BITS-1:0]  raddr;
   logic [RD_PORTS*DATA_WIDTH-1:0] data_out;
   logic [RD_PORTS-1:0]            rvalid;
   logic                           clr;
   logic                           busy;
   logic [RD_PORTS-1:0]            perr;

   modport master (
      output wen, waddr, data_in, ren, raddr, clr,
      input  data_out, rvalid, busy, perr
   );

   modport slave (
      input  wen, waddr, data_in, ren, raddr, clr,
      output data_out, rvalid, busy, perr
   );
endinterface

// File: rtl/reg_mem_clear_ctrl.sv
// Clear-sweep controller: IDLE/CLEAR FSM, sweep address counter and registered busy.
//  state    | meaning
//  ST_IDLE  | normal access, waiting for clr
//  ST_CLEAR | zeroing one word per cycle at the counter address
module reg_mem_clear_ctrl
   import reg_mem_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   output logic                 busy_o,
   output logic                 clr_en_o,
   output logic [ADDR_BITS-1:0] clr_addr_o
);
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] LAST_ADDR = (ADDR_BITS + 1)'(DEPTH - 1);
   localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS + 1)'(1);

   state_e             state_q, state_d;
   logic [ADDR_BITS:0] cnt_q, cnt_d;
   logic               busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == ST_CLEAR);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            // clr is deliberately not looked at here, so a held clr cannot restart the sweep
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      clr_en_o   = (state_q == ST_CLEAR);
      clr_addr_o = cnt_q[ADDR_BITS-1:0];
      busy_o     = busy_q;
   end

endmodule

// File: rtl/reg_mem_mp.sv
// Multi-read-port register memory with a write-first bypass on every port and a hardware clear sweep.
// The optional per-word parity is enabled with the REG_MEM_PARITY_EN macro.
module reg_mem_mp
   import reg_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_BITS  = DEF_ADDR_BITS,
   parameter int RD_PORTS   = DEF_RD_PORTS
) (
   input  logic          clk,
   input  logic          rst,
   reg_mem_mp_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_BITS;

   logic                  clr_en;
   logic [ADDR_BITS-1:0]  clr_addr;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   reg_mem_clear_ctrl #(
      .ADDR_BITS (ADDR_BITS)
   ) u_clear_ctrl (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (bus.clr),
      .busy_o     (bus.busy),
      .clr_en_o   (clr_en),
      .clr_addr_o (clr_addr)
   );

   assign wr_en = bus.wen & ~clr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else if (clr_en) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_en) begin
         mem_q[bus.waddr] <= bus.data_in;
      end
   end

`ifdef REG_MEM_PARITY_EN
   logic mem_par_q [DEPTH];
   logic wr_par;

   assign wr_par = parity_even(64'(bus.data_in));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_par_q[k] <= 1'b0;
         end
      end else if (clr_en) begin
         mem_par_q[clr_addr] <= 1'b0;
      end else if (wr_en) begin
         mem_par_q[bus.waddr] <= wr_par;
      end
   end
`endif

   for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [ADDR_BITS-1:0]  ra;
      logic                  byp;
      logic [DATA_WIDTH-1:0] rd_d;
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rvalid_q;

      assign ra   = bus.raddr[gi*ADDR_BITS +: ADDR_BITS];
      assign byp  = wr_en && (bus.waddr == ra);
      assign rd_d = byp ? bus.data_in : mem_q[ra];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
         end else if (bus.ren[gi] && !clr_en) begin
            dout_q   <= rd_d;
            rvalid_q <= 1'b1;
         end else begin
            rvalid_q <= 1'b0;
         end
      end

      assign bus.data_out[gi*DATA_WIDTH +: DATA_WIDTH] = dout_q;
      assign bus.rvalid[gi] = rvalid_q;

`ifdef REG_MEM_PARITY_EN
      logic perr_d;
      logic perr_q;

      // Bypassed data was never stored, so its parity is trusted.
      assign perr_d = byp ? 1'b0 : (parity_even(64'(mem_q[ra])) != mem_par_q[ra]);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            perr_q <= 1'b0;
         end else if (bus.ren[gi] && !clr_en) begin
            perr_q <= perr_d;
         end else begin
            perr_q <= 1'b0;
         end
      end

      assign bus.perr[gi] = perr_q;
`else
      assign bus.perr[gi] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_reg_mem_mp.sv
// Self-checking bench for reg_mem_mp: directed test-plan steps followed by random traffic against an array model.
module tb_reg_mem_mp;
   localparam int DW    = 4;
   localparam int AB    = 3;
   localparam int NP    = 2;
   localparam int DEPTH = 8;

   logic clk;
   logic rst;

   reg_mem_mp_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .RD_PORTS(NP)) bus ();

   reg_mem_mp #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .RD_PORTS(NP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: word contents, remaining sweep cycles, expected port outputs.
   int       model_mem [DEPTH];
   bit       model_bad [DEPTH];
   int       sweep_left;
   logic [3:0] exp_dout [NP];
   logic       exp_rv   [NP];
   logic       exp_perr [NP];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         model_mem[k] = 0;
         model_bad[k] = 1'b0;
      end
      sweep_left = 0;
      for (int p = 0; p < NP; p++) begin
         exp_dout[p] = '0;
         exp_rv[p]   = 1'b0;
         exp_perr[p] = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("%s rvalid[%0d]", tag, p), 32'(bus.rvalid[p]), 32'(exp_rv[p]));
         chk($sformatf("%s data_out[%0d]", tag, p), 32'(bus.data_out[p*DW +: DW]), 32'(exp_dout[p]));
         chk($sformatf("%s perr[%0d]", tag, p), 32'(bus.perr[p]), 32'(exp_perr[p]));
      end
      chk($sformatf("%s busy", tag), 32'(bus.busy), 32'(sweep_left > 0));
   endtask

   // One clock: drive inputs, take the edge, advance the model, compare.
   task automatic step(input string tag, input logic w, input int wa, input int wd,
                       input logic [1:0] r, input int ra0, input int ra1, input logic c);
      int ra [NP];
      bus.wen     = w;
      bus.waddr   = wa[AB-1:0];
      bus.data_in = wd[DW-1:0];
      bus.ren     = r;
      bus.raddr   = {ra1[AB-1:0], ra0[AB-1:0]};
      bus.clr     = c;
      ra[0] = ra0;
      ra[1] = ra1;
      @(posedge clk);
      #1;
      if (sweep_left == 0) begin
         if (w) begin
            model_mem[wa] = wd & 15;
            model_bad[wa] = 1'b0;
         end
         for (int p = 0; p < NP; p++) begin
            if (r[p]) begin
               exp_dout[p] = 4'(model_mem[ra[p]]);
               exp_rv[p]   = 1'b1;
               exp_perr[p] = model_bad[ra[p]];
            end else begin
               exp_rv[p]   = 1'b0;
               exp_perr[p] = 1'b0;
            end
         end
         if (c) sweep_left = DEPTH;
      end else begin
         sweep_left--;
         for (int p = 0; p < NP; p++) begin
            exp_rv[p]   = 1'b0;
            exp_perr[p] = 1'b0;
         end
         if (sweep_left == 0) begin
            for (int k = 0; k < DEPTH; k++) begin
               model_mem[k] = 0;
               model_bad[k] = 1'b0;
            end
         end
      end
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      bus.wen     = 1'b0;
      bus.waddr   = '0;
      bus.data_in = '0;
      bus.ren     = '0;
      bus.raddr   = '0;
      bus.clr     = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      idle_inputs();
      model_reset();
      rst = 1'b1;
      #1;
      check_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) step($sformatf("rd_after_reset a%0d", i), 1'b0, 0, 0, 2'b11, i, i, 1'b0);

      for (int i = 0; i < DEPTH; i++) step($sformatf("wr a%0d", i), 1'b1, i, 10 + i, 2'b00, 0, 0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step($sformatf("dual_rd i%0d", i), 1'b0, 0, 0, 2'b11, i, 7 - i, 1'b0);
      step("hold", 1'b0, 0, 0, 2'b00, 1, 2, 1'b0);
      step("port1_only", 1'b0, 0, 0, 2'b10, 4, 6, 1'b0);

      step("bypass_pre", 1'b1, 3, 5, 2'b00, 0, 0, 1'b0);
      step("bypass", 1'b1, 3, 9, 2'b11, 3, 3, 1'b0);
      step("bypass_after", 1'b0, 0, 0, 2'b11, 3, 3, 1'b0);

      for (int i = 0; i < DEPTH; i++) step($sformatf("fill a%0d", i), 1'b1, i, 15, 2'b00, 0, 0, 1'b0);
      step("clr_start", 1'b0, 0, 0, 2'b00, 0, 0, 1'b1);
      busy_cycles = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (bus.busy) busy_cycles++;
         step($sformatf("sweep c%0d", i), 1'b1, i % DEPTH, 7, 2'b11, i % DEPTH, (i + 1) % DEPTH, 1'(i == 2));
      end
      chk("busy_cycle_count", 32'(busy_cycles), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) step($sformatf("rd_after_clr a%0d", i), 1'b0, 0, 0, 2'b11, i, 7 - i, 1'b0);

      step("wr_clr_same", 1'b1, 5, 12, 2'b01, 5, 0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step($sformatf("sweep2 c%0d", i), 1'b0, 0, 0, 2'b11, 5, 5, 1'b0);
      step("rd_5_cleared", 1'b0, 0, 0, 2'b11, 5, 5, 1'b0);

      for (int i = 0; i < DEPTH; i++) step($sformatf("fill2 a%0d", i), 1'b1, i, 11, 2'b00, 0, 0, 1'b0);
      step("rd_before_abort", 1'b0, 0, 0, 2'b11, 1, 2, 1'b0);
      step("clr_abort", 1'b0, 0, 0, 2'b00, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) step($sformatf("abort c%0d", i), 1'b0, 0, 0, 2'b00, 0, 0, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs("mid_sweep_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) step($sformatf("rd_after_abort a%0d", i), 1'b0, 0, 0, 2'b11, i, i, 1'b0);
      step("clr_full", 1'b0, 0, 0, 2'b00, 0, 0, 1'b1);
      busy_cycles = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (bus.busy) busy_cycles++;
         step($sformatf("sweep3 c%0d", i), 1'b0, 0, 0, 2'b00, 0, 0, 1'b0);
      end
      chk("busy_cycle_count_after_reset", 32'(busy_cycles), 32'(DEPTH));

`ifdef REG_MEM_PARITY_EN
      step("par_wr", 1'b1, 2, 6, 2'b00, 0, 0, 1'b0);
      dut.mem_par_q[2] = ~dut.mem_par_q[2];
      model_bad[2] = 1'b1;
      step("par_flip_rd", 1'b0, 0, 0, 2'b11, 0, 2, 1'b0);
      chk("perr1_set", 32'(bus.perr[1]), 32'd1);
      chk("perr0_clear", 32'(bus.perr[0]), 32'd0);
      step("par_rewr", 1'b1, 2, 6, 2'b00, 0, 0, 1'b0);
      step("par_good_rd", 1'b0, 0, 0, 2'b11, 2, 2, 1'b0);
`endif

      for (int n = 0; n < 300; n++) begin
         step($sformatf("rand n%0d", n), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 24) == 0));
      end

      idle_inputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
